lsu_ctrl: RTL and testbench

//  Load/store sequencer between the core's execute stage and the data bus. Takes one

---
 rtl/lsu_ctrl_if.sv | 37 +++
 rtl/lsu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request/response and data-bus signal bundle for lsu_ctrl
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [9:0]            req_funct;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_fault;
    logic                  bus_addr_valid;
    logic                  bus_addr_ready;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_write;
    logic [31:0]           bus_wdata;
    logic [3:0]            bus_wstrb;
    logic                  bus_resp_valid;
    logic                  bus_resp_ready;
    logic [31:0]           bus_rdata;

    modport master (
        input  req_valid, req_store, req_funct, req_addr, req_wdata,
        input  bus_addr_ready, bus_resp_valid, bus_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output bus_addr_valid, bus_addr, bus_write, bus_wdata, bus_wstrb, bus_resp_ready
    );

    modport slave (
        output req_valid, req_store, req_funct, req_addr, req_wdata,
        output bus_addr_ready, bus_resp_valid, bus_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  bus_addr_valid, bus_addr, bus_write, bus_wdata, bus_wstrb, bus_resp_ready
    );
endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store sequencer with alignment checks
// Optional RESP watchdog enabled by defining LSU_BUS_TIMEOUT_EN.
module lsu_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.master lsu
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_e                state_q, state_d;
    logic                  store_q, store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic                  req_bad;
    logic [1:0]            off;
    logic [31:0]           lane, load_ext, st_wdata;
    logic [3:0]            st_wstrb;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Illegal encodings and misalignment are both resolved before any bus traffic.
    always_comb begin
        req_bad = 1'b0;
        if (lsu.req_funct[9:3] != 7'd0) begin
            req_bad = 1'b1;
        end else begin
            case ({lsu.req_store, lsu.req_funct[2:0]})
                {1'b0, F3_B}, {1'b0, F3_BU}, {1'b1, F3_B}: req_bad = 1'b0;
                {1'b0, F3_H}, {1'b0, F3_HU}, {1'b1, F3_H}: req_bad = lsu.req_addr[0];
                {1'b0, F3_W}, {1'b1, F3_W}:                req_bad = |lsu.req_addr[1:0];
                default:                                   req_bad = 1'b1;
            endcase
        end
    end

    assign off  = addr_q[1:0];
    assign lane = lsu.bus_rdata >> {off, 3'b000};

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = wdata_q;
        case (funct3_q)
            F3_B: begin
                st_wstrb = 4'b0001 << off;
                st_wdata = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                st_wstrb = 4'b0011 << off;
                st_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_ext = lane;
        case (funct3_q)
            F3_B:    load_ext = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_ext = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   load_ext = {24'd0, lane[7:0]};
            F3_HU:   load_ext = {16'd0, lane[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
`ifdef LSU_BUS_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (lsu.req_valid) begin
                    store_d  = lsu.req_store;
                    funct3_d = lsu.req_funct[2:0];
                    addr_d   = lsu.req_addr;
                    wdata_d  = lsu.req_wdata;
                    rdata_d  = 32'd0;
                    fault_d  = req_bad;
                    state_d  = req_bad ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                if (lsu.bus_addr_ready) begin
                    state_d = S_RESP;
`ifdef LSU_BUS_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_RESP: begin
                if (lsu.bus_resp_valid) begin
                    rdata_d = store_q ? 32'd0 : load_ext;
                    fault_d = 1'b0;
                    state_d = S_DONE;
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    rdata_d = 32'd0;
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
`ifdef LSU_BUS_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign lsu.req_ready      = (state_q == S_IDLE);
    assign lsu.resp_valid     = (state_q == S_DONE);
    assign lsu.resp_rdata     = (state_q == S_DONE) ? rdata_q : 32'd0;
    assign lsu.resp_fault     = (state_q == S_DONE) && fault_q;
    assign lsu.bus_addr_valid = (state_q == S_ADDR);
    assign lsu.bus_resp_ready = (state_q == S_RESP);
    assign lsu.bus_addr       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign lsu.bus_write      = store_q;
    assign lsu.bus_wdata      = store_q ? st_wdata : 32'd0;
    assign lsu.bus_wstrb      = store_q ? st_wstrb : 4'd0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized bench for lsu_ctrl against a transaction-level model
module tb_lsu_ctrl;
    localparam int AW  = 32;
    localparam int TMO = 4;

    typedef struct {
        logic        fault;
        logic        write;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    lsu_ctrl_if #(.ADDR_WIDTH(AW)) bus_if ();
    lsu_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .lsu(bus_if));

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned cyc0 = 0;
    bit          checking = 0;
    bit          outstanding = 0;
    bit          addr_done = 0;
    bit          resp_done = 0;
    exp_t        cur;
    logic [31:0] last_baddr, last_bwdata, last_rdata;
    logic [3:0]  last_wstrb;
    logic        last_fault;
    int          last_lat;
    logic        exp_av, exp_rr, exp_rv;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input bit st, input logic [9:0] f, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd);
        exp_t        e;
        int          size, o;
        bit          sgn, legal;
        logic [31:0] mask, val;
        e = '{default: '0};
        legal = (f[9:3] == 0);
        sgn = 0;
        size = 4;
        if (st) begin
            case (f[2:0])
                3'd0: size = 1;
                3'd1: size = 2;
                3'd2: size = 4;
                default: legal = 0;
            endcase
        end else begin
            case (f[2:0])
                3'd0: begin size = 1; sgn = 1; end
                3'd1: begin size = 2; sgn = 1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: legal = 0;
            endcase
        end
        o = int'(a % 4);
        e.fault = !legal || (a % size != 0);
        e.write = st;
        e.baddr = a - o;
        if (!e.fault) begin
            if (st) begin
                e.wstrb = 4'(((1 << size) - 1) << o);
                for (int i = 0; i < 4; i++) e.bwdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end else begin
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
                val = (rd >> (8 * o)) & mask;
                if (sgn && val[8*size-1]) val = val | ~mask;
                e.rdata = val;
            end
        end
        return e;
    endfunction

    // Every cycle, the observable handshake lines follow from where the bench's transaction stands.
    always @(negedge clk) begin
        if (checking && rst) begin
            exp_av = outstanding && !cur.fault && !addr_done;
            exp_rr = outstanding && !cur.fault && addr_done && !resp_done;
            exp_rv = outstanding && (cur.fault || resp_done);
            chk("req_ready", 32'(bus_if.req_ready), 32'(!outstanding));
            chk("bus_addr_valid", 32'(bus_if.bus_addr_valid), 32'(exp_av));
            chk("bus_resp_ready", 32'(bus_if.bus_resp_ready), 32'(exp_rr));
            chk("resp_valid", 32'(bus_if.resp_valid), 32'(exp_rv));
            if (exp_av) begin
                chk("bus_addr", bus_if.bus_addr, cur.baddr);
                chk("bus_write", 32'(bus_if.bus_write), 32'(cur.write));
                chk("bus_wstrb", 32'(bus_if.bus_wstrb), 32'(cur.wstrb));
                if (cur.write) chk("bus_wdata", bus_if.bus_wdata, cur.bwdata);
            end
            if (exp_rv) begin
                chk("resp_rdata", bus_if.resp_rdata, cur.rdata);
                chk("resp_fault", 32'(bus_if.resp_fault), 32'(cur.fault));
            end
        end
    end

    function automatic logic sig(input int s);
        case (s)
            0: return bus_if.req_ready;
            1: return bus_if.bus_addr_valid;
            2: return bus_if.bus_resp_ready;
            default: return bus_if.resp_valid;
        endcase
    endfunction

    task automatic wait_high(input int s, input string name);
        int n = 0;
        @(negedge clk);
        while (!sig(s) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sig(s)) begin
            checks++;
            errors++;
            $display("FAIL %s: wait bound expired, got 0 expected 1", name);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit st, input logic [9:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int ad, input int rdl);
        exp_t e;
        e = model(st, f, a, wd, rd);
        bus_if.req_valid = 1'b1;
        bus_if.req_store = st;
        bus_if.req_funct = f;
        bus_if.req_addr  = a;
        bus_if.req_wdata = wd;
        wait_high(0, "req_accept");
        step();
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = $urandom;
        bus_if.req_wdata = $urandom;
        bus_if.req_funct = 10'($urandom);
        cur = e;
        outstanding = 1;
        addr_done = 0;
        resp_done = 0;
        cyc0 = cyc;
        if (!e.fault) begin
            for (int i = 0; i < ad; i++) begin
                bus_if.bus_addr_ready = 1'b0;
                bus_if.bus_resp_valid = 1'($urandom);
                bus_if.bus_rdata = $urandom;
                step();
            end
            bus_if.bus_resp_valid = 1'b0;
            bus_if.bus_addr_ready = 1'b1;
            wait_high(1, "bus_addr_valid_wait");
            last_baddr  = bus_if.bus_addr;
            last_wstrb  = bus_if.bus_wstrb;
            last_bwdata = bus_if.bus_wdata;
            step();
            bus_if.bus_addr_ready = 1'b0;
            addr_done = 1;
            for (int i = 0; i < rdl; i++) begin
                bus_if.bus_rdata = $urandom;
                step();
            end
            bus_if.bus_resp_valid = 1'b1;
            bus_if.bus_rdata = rd;
            wait_high(2, "bus_resp_ready_wait");
            step();
            bus_if.bus_resp_valid = 1'b0;
            bus_if.bus_rdata = $urandom;
            resp_done = 1;
        end
        wait_high(3, "resp_valid_wait");
        last_rdata = bus_if.resp_rdata;
        last_fault = bus_if.resp_fault;
        last_lat   = int'(cyc - cyc0) + 1;
        step();
        outstanding = 0;
    endtask

    task automatic start_to_resp(input bit st, input logic [9:0] f, input logic [31:0] a,
                                 input logic [31:0] wd);
        bus_if.req_valid = 1'b1;
        bus_if.req_store = st;
        bus_if.req_funct = f;
        bus_if.req_addr  = a;
        bus_if.req_wdata = wd;
        wait_high(0, "req_accept");
        step();
        bus_if.req_valid = 1'b0;
        cyc0 = cyc;
        bus_if.bus_addr_ready = 1'b1;
        wait_high(1, "bus_addr_valid_wait");
        step();
        bus_if.bus_addr_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus_if.req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(bus_if.resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, bus_if.resp_rdata, 32'd0);
        chk({tag, "_resp_fault"}, 32'(bus_if.resp_fault), 32'd0);
        chk({tag, "_bus_addr_valid"}, 32'(bus_if.bus_addr_valid), 32'd0);
        chk({tag, "_bus_resp_ready"}, 32'(bus_if.bus_resp_ready), 32'd0);
        chk({tag, "_bus_addr"}, bus_if.bus_addr, 32'd0);
        chk({tag, "_bus_write"}, 32'(bus_if.bus_write), 32'd0);
        chk({tag, "_bus_wdata"}, bus_if.bus_wdata, 32'd0);
        chk({tag, "_bus_wstrb"}, 32'(bus_if.bus_wstrb), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          st, seen;
        logic [9:0]  f;
        logic [31:0] a;
        bus_if.req_valid = 0;
        bus_if.req_store = 0;
        bus_if.req_funct = 0;
        bus_if.req_addr = 0;
        bus_if.req_wdata = 0;
        bus_if.bus_addr_ready = 0;
        bus_if.bus_resp_valid = 0;
        bus_if.bus_rdata = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        step();
        checking = 1;

        do_req(0, 10'd0, 32'h1003, 32'h0, 32'h8011_2233, 0, 0);
        chk("lb_bus_addr", last_baddr, 32'h1000);
        chk("lb_wstrb", 32'(last_wstrb), 32'd0);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        chk("lb_latency", 32'(last_lat), 32'd3);

        do_req(0, 10'd5, 32'h1002, 32'h0, 32'h8011_2233, 0, 0);
        chk("lhu_rdata", last_rdata, 32'h0000_8011);
        chk("lhu_fault", 32'(last_fault), 32'd0);

        do_req(1, 10'd1, 32'h2002, 32'h0000_BEEF, 32'h1234_5678, 0, 0);
        chk("sh_bus_addr", last_baddr, 32'h2000);
        chk("sh_wstrb", 32'(last_wstrb), 32'hC);
        chk("sh_wdata", last_bwdata, 32'hBEEF_BEEF);
        chk("sh_rdata", last_rdata, 32'd0);

        do_req(0, 10'd2, 32'h3001, 32'h0, 32'hFFFF_FFFF, 0, 0);
        chk("lw_mis_fault", 32'(last_fault), 32'd1);
        chk("lw_mis_latency", 32'(last_lat), 32'd1);
        chk("lw_mis_rdata", last_rdata, 32'd0);

        do_req(1, 10'd2, 32'h5000, 32'hCAFE_F00D, 32'h0, 5, 0);
        chk("sw_stall_latency", 32'(last_lat), 32'd8);
        chk("sw_stall_wdata", last_bwdata, 32'hCAFE_F00D);

        do_req(0, 10'd2, 32'h6000, 32'h0, 32'hA5A5_0F0F, 0, TMO - 1);
        chk("limit_resp_fault", 32'(last_fault), 32'd0);
        chk("limit_resp_rdata", last_rdata, 32'hA5A5_0F0F);
        chk("limit_resp_latency", 32'(last_lat), 32'd6);

        checking = 0;
        start_to_resp(0, 10'd2, 32'h4000, 32'h0);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus_if.resp_valid) begin
                seen = 1;
                last_rdata = bus_if.resp_rdata;
                last_fault = bus_if.resp_fault;
                last_lat   = int'(cyc - cyc0) + 1;
            end
        end
`ifdef LSU_BUS_TIMEOUT_EN
        chk("timeout_seen", 32'(seen), 32'd1);
        chk("timeout_fault", 32'(last_fault), 32'd1);
        chk("timeout_rdata", last_rdata, 32'd0);
        chk("timeout_latency", 32'(last_lat), 32'd6);
        step();
`else
        chk("no_timeout_seen", 32'(seen), 32'd0);
        chk("no_timeout_resp_ready", 32'(bus_if.bus_resp_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
`endif

        start_to_resp(1, 10'd0, 32'h7001, 32'h0000_00A5);
        @(negedge clk);
        chk("rst_pre_resp_ready", 32'(bus_if.bus_resp_ready), 32'd1);
        chk("rst_pre_wstrb", 32'(bus_if.bus_wstrb), 32'h2);
        bus_if.bus_resp_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_resp");
        @(negedge clk);
        bus_if.bus_resp_valid = 1'b0;
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst_after_resp_valid", 32'(bus_if.resp_valid), 32'd0);
            chk("rst_after_req_ready", 32'(bus_if.req_ready), 32'd1);
        end
        step();
        checking = 1;

        for (int t = 0; t < 150; t++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bus_if.bus_resp_valid = 1'($urandom);
                bus_if.bus_addr_ready = 1'($urandom);
                bus_if.bus_rdata = $urandom;
                step();
            end
            bus_if.bus_resp_valid = 1'b0;
            bus_if.bus_addr_ready = 1'b0;
            st = 1'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                if (st) f = 10'($urandom_range(0, 2));
                else begin
                    case ($urandom_range(0, 4))
                        0: f = 10'd0;
                        1: f = 10'd1;
                        2: f = 10'd2;
                        3: f = 10'd4;
                        default: f = 10'd5;
                    endcase
                end
            end else begin
                f = 10'($urandom);
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_req(st, f, a, $urandom, $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, TMO - 1)));
        end

        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
